// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan controller for a multi-digit
// 7-segment display. Walks a one-hot digit select across the slots, PWM-dims
// each slot via on_signal, blanks a leading-zero top digit, and snapshots the
// digit/brightness inputs once per frame so a displayed frame never tears.
module display_scanner #(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_DIV    = 16,
  parameter int PWM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    enable,
  input  logic                    blank_lz,
  output logic [3:0]              number,
  output logic                    on_signal,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [PWM_BITS-1:0]     step_q, step_d;
  logic [SW-1:0]           slot_q, slot_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PWM_BITS-1:0]     bright_q, bright_d;
  logic [3:0]              number_q, number_d;
  logic                    on_signal_q, on_signal_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    frame_start_q, frame_start_d;

  logic tick;
  logic step_wrap;
  logic frame_wrap;
  logic lz_blank;

  // Next-state of the prescaler / step / slot counter chain and the frame snapshot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    presc_d  = presc_q;
    step_d   = step_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    bright_d = bright_q;

    tick       = (presc_q == PRESC_LAST);
    step_wrap  = tick && (step_q == '1);
    frame_wrap = step_wrap && (slot_q == SLOT_LAST);

    presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick) begin
      step_d = step_q + PWM_BITS'(1);
    end
    if (step_wrap) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    end

    // Entering slot 0 / step 0 / presc 0: latch the frame's contents.
    if (frame_wrap) begin
      shadow_d = digits_in;
      bright_d = brightness;
    end
  end

  // Output values computed from next-state so outputs line up with the counters.
  always_comb begin
    number_d    = '0;
    digit_sel_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (slot_d == SW'(k)) begin
        number_d       = shadow_d[4*k +: 4];
        digit_sel_d[k] = 1'b1;
      end
    end

    lz_blank = blank_lz && (slot_d == SLOT_LAST) &&
               (shadow_d[4*NUM_DIGITS-1 -: 4] == 4'd0);

    // Step 0 is always dark so segments are off while digit_sel changes.
    on_signal_d = enable && (step_d != '0) && (step_d <= bright_d) && !lz_blank;

    frame_start_d = frame_wrap;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow copy is reset too, so the first frame after reset is defined (all zero, dark).
      presc_q       <= '0;
      step_q        <= '0;
      slot_q        <= '0;
      shadow_q      <= '0;
      bright_q      <= '0;
      number_q      <= '0;
      on_signal_q   <= 1'b0;
      digit_sel_q   <= NUM_DIGITS'(1);
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      presc_q       <= presc_d;
      step_q        <= step_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      bright_q      <= bright_d;
      number_q      <= number_d;
      on_signal_q   <= on_signal_d;
      digit_sel_q   <= digit_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign number      = number_q;
  assign on_signal   = on_signal_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (6 digits, CLK_DIV=2, PWM_BITS=2).
// The reference model tracks the position inside the frame as a plain clock
// count since reset and derives slot/step/expected outputs arithmetically.
module tb_display_scanner;

  localparam int ND    = 6;
  localparam int CD    = 2;
  localparam int PB    = 2;
  localparam int STEPS = 1 << PB;
  localparam int SLOT  = CD * STEPS;   // 8 clocks
  localparam int FRAME = ND * SLOT;    // 48 clocks

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] digits_in;
  logic [PB-1:0] brightness;
  logic          enable;
  logic          blank_lz;
  logic [3:0]    number;
  logic          on_signal;
  logic [ND-1:0] digit_sel;
  logic          frame_start;

  display_scanner #(.NUM_DIGITS(ND), .CLK_DIV(CD), .PWM_BITS(PB)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .brightness (brightness),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .number     (number),
    .on_signal  (on_signal),
    .digit_sel  (digit_sel),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int              t;          // clocks into the current frame, 0..FRAME-1
  logic [4*ND-1:0] m_dig;      // snapshot digits
  int              m_br;       // snapshot brightness
  logic [3:0]      exp_num;
  logic            exp_on;
  logic [ND-1:0]   exp_sel;
  logic            exp_fs;

  function automatic int cur_slot();
    return t / SLOT;
  endfunction

  function automatic int cur_step();
    return (t % SLOT) / CD;
  endfunction

  task automatic model_reset();
    t       = 0;
    m_dig   = '0;
    m_br    = 0;
    exp_num = 4'd0;
    exp_on  = 1'b0;
    exp_sel = ND'(1);
    exp_fs  = 1'b0;
  endtask

  // One clock: update the model with inputs seen at the edge, then move to
  // the falling edge where outputs are compared.
  task automatic cyc();
    int   s;
    int   st;
    logic lz;
    @(posedge clk);
    t = (t + 1) % FRAME;
    exp_fs = (t == 0);
    if (t == 0) begin
      m_dig = digits_in;
      m_br  = int'(brightness);
    end
    s       = cur_slot();
    st      = cur_step();
    exp_num = m_dig[4*s +: 4];
    exp_sel = ND'(1) << s;
    lz      = blank_lz && (s == ND - 1) && (m_dig[4*ND-1 -: 4] == 4'd0);
    exp_on  = enable && (st != 0) && (st <= m_br) && !lz;
    @(negedge clk);
  endtask

  // Advance until the model sits at the start of a new frame (bounded).
  task automatic align_frame();
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      if (t == 0) break;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    digits_in  = 24'h123456;
    brightness = 2'd3;
    enable     = 1'b1;
    blank_lz   = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({number, on_signal, digit_sel, frame_start} !== {4'd0, 1'b0, 6'b000001, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: got num=%0d on=%b sel=%b fs=%b, want num=0 on=0 sel=000001 fs=0",
               number, on_signal, digit_sel, frame_start);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 2 * FRAME; i++) begin
      cyc();
      vectors++;
      if ({number, on_signal, digit_sel, frame_start} !== {exp_num, exp_on, exp_sel, exp_fs}) begin
        miscompares++;
        $display("FAIL reset_seq clk %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 number, on_signal, digit_sel, frame_start, exp_num, exp_on, exp_sel, exp_fs);
      end
      if (i < FRAME) begin
        vectors++;
        if (on_signal !== 1'b0 || digit_sel !== ND'(1) << (i / SLOT)) begin
          miscompares++;
          $display("FAIL first_frame_dark clk %0d: got on=%b sel=%b want on=0 sel=%b",
                   i, on_signal, digit_sel, ND'(1) << (i / SLOT));
        end
      end
      if (i == FRAME) begin
        vectors++;
        if (frame_start !== 1'b1) begin
          miscompares++;
          $display("FAIL frame_start_48: got %b want 1", frame_start);
        end
      end
      if (i > FRAME && (i % SLOT) == 4) begin
        vectors++;
        if (number !== 4'(6 - (i - FRAME) / SLOT)) begin
          miscompares++;
          $display("FAIL second_frame_number clk %0d: got %0d want %0d",
                   i, number, 6 - (i - FRAME) / SLOT);
        end
      end
    end
  endtask

  task automatic test_pwm();
    int lit [ND];
    int levels [3] = '{3, 1, 0};
    foreach (levels[li]) begin
      brightness = PB'(levels[li]);
      digits_in  = 24'($urandom);
      enable     = 1'b1;
      blank_lz   = 1'b0;
      align_frame();
      foreach (lit[k]) lit[k] = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (on_signal === 1'b1) lit[cur_slot()]++;
        vectors++;
        if ({number, on_signal, digit_sel, frame_start} !== {exp_num, exp_on, exp_sel, exp_fs}) begin
          miscompares++;
          $display("FAIL pwm_model br=%0d t=%0d: got %h/%b/%b/%b want %h/%b/%b/%b", levels[li], t,
                   number, on_signal, digit_sel, frame_start, exp_num, exp_on, exp_sel, exp_fs);
        end
        if ((t % SLOT) < CD) begin
          vectors++;
          if (on_signal !== 1'b0) begin
            miscompares++;
            $display("FAIL pwm_ghost_guard t=%0d: got on=%b want 0", t, on_signal);
          end
        end
        cyc();
      end
      foreach (lit[k]) begin
        vectors++;
        if (lit[k] != CD * levels[li]) begin
          miscompares++;
          $display("FAIL pwm_duty br=%0d slot %0d: got %0d lit clocks want %0d",
                   levels[li], k, lit[k], CD * levels[li]);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    digits_in  = 24'h111111;
    brightness = 2'd3;
    align_frame();
    for (int i = 0; i < FRAME - 1; i++) begin
      if (t == 20) digits_in = 24'h999999;
      cyc();
      vectors++;
      if (number !== 4'd1 || exp_num !== 4'd1) begin
        miscompares++;
        $display("FAIL snapshot_hold t=%0d: got %0d want 1", t, number);
      end
    end
    cyc();
    vectors++;
    if (number !== 4'd9 || frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL snapshot_load: got num=%0d fs=%b want num=9 fs=1", number, frame_start);
    end
  endtask

  task automatic test_lz();
    int lit [ND];
    digits_in  = 24'h012345;
    brightness = 2'd3;
    enable     = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      blank_lz = (pass == 0);
      align_frame();
      foreach (lit[k]) lit[k] = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (on_signal === 1'b1) lit[cur_slot()]++;
        vectors++;
        if ({number, on_signal, digit_sel, frame_start} !== {exp_num, exp_on, exp_sel, exp_fs}) begin
          miscompares++;
          $display("FAIL lz_model blz=%0d t=%0d: got %h/%b/%b/%b want %h/%b/%b/%b", pass == 0, t,
                   number, on_signal, digit_sel, frame_start, exp_num, exp_on, exp_sel, exp_fs);
        end
        cyc();
      end
      foreach (lit[k]) begin
        vectors++;
        if (lit[k] != ((pass == 0 && k == ND - 1) ? 0 : 6)) begin
          miscompares++;
          $display("FAIL lz_blank blz=%0d slot %0d: got %0d lit want %0d", pass == 0, k, lit[k],
                   (pass == 0 && k == ND - 1) ? 0 : 6);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_enable_invalid();
    digits_in  = 24'h000F00;
    brightness = 2'd3;
    enable     = 1'b1;
    align_frame();
    while (t != 2 * SLOT + 3) cyc();
    vectors++;
    if (number !== 4'd15 || on_signal !== 1'b1 || digit_sel !== 6'b000100) begin
      miscompares++;
      $display("FAIL invalid_code: got num=%0d on=%b sel=%b want num=15 on=1 sel=000100",
               number, on_signal, digit_sel);
    end
    enable = 1'b0;
    cyc();
    vectors++;
    if (on_signal !== 1'b0 || digit_sel !== 6'b000100) begin
      miscompares++;
      $display("FAIL enable_off: got on=%b sel=%b want on=0 sel=000100", on_signal, digit_sel);
    end
    enable = 1'b1;
    cyc();
    vectors++;
    if (on_signal !== 1'b1 || digit_sel !== 6'b000100 || number !== 4'd15) begin
      miscompares++;
      $display("FAIL enable_resume: got on=%b sel=%b num=%0d want on=1 sel=000100 num=15",
               on_signal, digit_sel, number);
    end
  endtask

  task automatic test_mid_reset();
    digits_in  = 24'h987654;
    brightness = 2'd2;
    align_frame();
    while (t != 3 * SLOT + 3) cyc();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({number, on_signal, digit_sel, frame_start} !== {4'd0, 1'b0, 6'b000001, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset_async: got num=%0d on=%b sel=%b fs=%b want 0/0/000001/0",
               number, on_signal, digit_sel, frame_start);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 2 * FRAME; i++) begin
      cyc();
      vectors++;
      if ({number, on_signal, digit_sel, frame_start} !== {exp_num, exp_on, exp_sel, exp_fs}) begin
        miscompares++;
        $display("FAIL mid_reset_after clk %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 number, on_signal, digit_sel, frame_start, exp_num, exp_on, exp_sel, exp_fs);
      end
      if (i < FRAME) begin
        vectors++;
        if (on_signal !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_reset_dark clk %0d: got on=%b want 0", i, on_signal);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        digits_in = 24'($urandom);
        if ($urandom_range(0, 1) == 1) digits_in[4*ND-1 -: 4] = 4'd0;
      end
      if ($urandom_range(0, 19) == 0) brightness = PB'($urandom);
      if ($urandom_range(0, 9) == 0)  enable     = 1'($urandom);
      if ($urandom_range(0, 9) == 0)  blank_lz   = 1'($urandom);
      cyc();
      vectors++;
      if ({number, on_signal, digit_sel, frame_start} !== {exp_num, exp_on, exp_sel, exp_fs}) begin
        miscompares++;
        $display("FAIL random t=%0d: got %h/%b/%b/%b want %h/%b/%b/%b", t,
                 number, on_signal, digit_sel, frame_start, exp_num, exp_on, exp_sel, exp_fs);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pwm();
    test_snapshot();
    test_lz();
    test_enable_invalid();
    test_mid_reset();
    apply_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
